// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Request/acknowledge bundle for one requester of the shared memory arbiter.
// One instance is used for the core port and one for the DMA port.
//   req, we, addr, wdata : requester -> arbiter; held stable until ack
//   ack                  : arbiter -> requester; one-cycle completion pulse
//   rdata                : arbiter -> requester; read data, valid while ack=1
// Modports: master = requester side, slave = arbiter side.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one fixed-latency unified memory between the core's fetch/load/store
// port (c_port) and a DMA/loader port (d_port). Round-robin arbitration, one
// access in flight at a time; each access runs IDLE -> ISSUE -> WAIT (LAT
// cycles) -> RESP and ends with a one-cycle ack carrying the read data.
// Ports:
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   c_port, d_port      : requester bundles (mem_arbiter_if.slave)
//   core_lock           : core asks to keep ownership for its next access
//   mem_en, mem_we,
//   mem_addr, mem_wdata : memory access strobe and fields, 0 outside ISSUE
//   mem_rdata           : memory read data, valid LAT cycles after mem_en
//   grant               : one-hot owner {DMA, core}, 0 when idle
// Optional feature: define MEM_ARB_LOCK_EN to honour core_lock (a core access
// completed with core_lock=1 gives the core the next grant if it still
// requests, without touching the round-robin pointer). Without the macro,
// core_lock is ignored.
module mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   c_port,
  mem_arbiter_if.slave   d_port,
  input  logic           core_lock,
  output logic           mem_en,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  output logic [1:0]     grant
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;        // 1 = DMA was granted last
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    grant_q, grant_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          lock_grant;
  logic          do_grant;
  logic          pick_dma;

`ifdef MEM_ARB_LOCK_EN
  // lock_q is only ever high in the IDLE cycle right after a locked core RESP
  logic lock_q, lock_d;

  always_comb begin
    lock_d = (state_q == RESP) && grant_q[0] && core_lock;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_q <= 1'b0;
    else       lock_q <= lock_d;
  end

  assign lock_grant = lock_q && c_port.req;
`else
  logic unused_core_lock;
  assign unused_core_lock = core_lock;
  assign lock_grant       = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      grant_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // A locked grant bypasses round-robin and leaves last unchanged; a tie goes
  // to the port that was not granted last.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    do_grant  = 1'b0;
    pick_dma  = 1'b0;
    case (state_q)
      IDLE: begin
        if (lock_grant) begin
          do_grant = 1'b1;
          pick_dma = 1'b0;
        end else if (c_port.req && d_port.req) begin
          do_grant = 1'b1;
          pick_dma = ~last_q;
          last_d   = ~last_q;
        end else if (c_port.req) begin
          do_grant = 1'b1;
          pick_dma = 1'b0;
          last_d   = 1'b0;
        end else if (d_port.req) begin
          do_grant = 1'b1;
          pick_dma = 1'b1;
          last_d   = 1'b1;
        end
        if (do_grant) begin
          we_d    = pick_dma ? d_port.we    : c_port.we;
          addr_d  = pick_dma ? d_port.addr  : c_port.addr;
          wdata_d = pick_dma ? d_port.wdata : c_port.wdata;
          grant_d = pick_dma ? 2'b10 : 2'b01;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (grant_q[1]) d_rdata_d = mem_rdata;
          else            c_rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q  : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;

  assign c_port.ack   = (state_q == RESP) & grant_q[0];
  assign d_port.ack   = (state_q == RESP) & grant_q[1];
  assign c_port.rdata = c_rdata_q;
  assign d_port.rdata = d_rdata_q;
  assign grant        = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. u_dut (LAT=1) is checked every cycle
// against a transaction-level model that predicts outputs from the cycle a
// grant is decided; u_dut3 (LAT=3) gets a directed latency check.
// Behaviour with MEM_ARB_LOCK_EN follows the macro at compile time.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L1 = 1;
  localparam int L3 = 3;

  logic clk = 1'b0;
  logic reset;
  logic core_lock;
  int   cyc = 0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.AW(AW), .DW(DW)) c_if ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) d_if ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) c3_if ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) d3_if ();

  logic          mem_en, mem_we, mem3_en, mem3_we;
  logic [AW-1:0] mem_addr, mem3_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, mem3_wdata, mem3_rdata;
  logic [1:0]    grant, grant3;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(L1)) u_dut (
    .clk(clk), .reset(reset), .c_port(c_if), .d_port(d_if),
    .core_lock(core_lock), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .grant(grant));

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(L3)) u_dut3 (
    .clk(clk), .reset(reset), .c_port(c3_if), .d_port(d3_if),
    .core_lock(core_lock), .mem_en(mem3_en), .mem_we(mem3_we),
    .mem_addr(mem3_addr), .mem_wdata(mem3_wdata), .mem_rdata(mem3_rdata),
    .grant(grant3));

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory behind u_dut: read data is only valid in the one cycle LAT after
  // mem_en, garbage otherwise, so early or late sampling is visible.
  logic [DW-1:0] phys_mem [logic [AW-1:0]];
  int            rd_due = -1;
  logic [DW-1:0] rd_val = '0;

  always @(posedge clk) begin
    if (!reset && mem_en) begin
      if (mem_we) phys_mem[mem_addr] = mem_wdata;
      else begin
        rd_due <= cyc + L1;
        rd_val <= phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : init_val(mem_addr);
      end
    end
  end
  assign mem_rdata = (cyc == rd_due) ? rd_val : {16'hBAD0, cyc[15:0]};

  int rd3_due = -1;
  always @(posedge clk) if (!reset && mem3_en) rd3_due <= cyc + L3;
  assign mem3_rdata = (cyc == rd3_due) ? 32'hCAFE_F00D : 32'h0BAD_0BAD;

  // Transaction model of u_dut plus observation logs for directed checks
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  bit            m_busy = 0, m_owner = 0, m_last = 1, m_lock = 0, m_we = 0;
  int            m_start = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] exp_rdata [2];
  bit            rd_known [2];
  int            en_count = 0, en_cycle = 0;
  logic [AW-1:0] en_addr = '0;
  logic          en_we = 1'b0;
  logic [DW-1:0] en_wdata = '0;
  int            ack_port_q [$];
  int            ack_cyc_q [$];

  always @(negedge clk) begin : model_compare
    logic [1:0]    e_grant, e_ack;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    int            ph;
    bit            done, go, own;
    if (mem_en) begin
      en_count++; en_cycle = cyc; en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata;
    end
    if (c_if.ack) begin ack_port_q.push_back(0); ack_cyc_q.push_back(cyc); end
    if (d_if.ack) begin ack_port_q.push_back(1); ack_cyc_q.push_back(cyc); end
    e_grant = '0; e_ack = '0; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    done = 0; go = 0; own = 0; ph = 0;
    if (reset) begin
      m_busy = 0; m_last = 1; m_lock = 0;
      exp_rdata[0] = '0; exp_rdata[1] = '0; rd_known[0] = 1; rd_known[1] = 1;
    end else if (m_busy) begin
      ph = cyc - m_start;
      e_grant = m_owner ? 2'b10 : 2'b01;
      if (ph == 1) begin
        e_en = 1; e_we = m_we; e_addr = m_addr; e_wdata = m_wdata;
        if (m_we) ref_mem[m_addr] = m_wdata;
      end
      if (ph == 2 + L1) begin
        e_ack[m_owner] = 1'b1;
        rd_known[m_owner] = !m_we;
        if (!m_we)
          exp_rdata[m_owner] = ref_mem.exists(m_addr) ? ref_mem[m_addr] : init_val(m_addr);
        done = 1;
      end
    end
    check_output("grant", grant, e_grant);
    check_output("mem_en", mem_en, e_en);
    check_output("mem_we", mem_we, e_we);
    check_output("mem_addr", mem_addr, e_addr);
    check_output("mem_wdata", mem_wdata, e_wdata);
    check_output("c_ack", c_if.ack, e_ack[0]);
    check_output("d_ack", d_if.ack, e_ack[1]);
    check_output("ack_exclusive", c_if.ack & d_if.ack, 0);
    if (rd_known[0]) check_output("c_rdata", c_if.rdata, exp_rdata[0]);
    if (rd_known[1]) check_output("d_rdata", d_if.rdata, exp_rdata[1]);
    if (!reset) begin
      if (done) begin
        m_busy = 0;
`ifdef MEM_ARB_LOCK_EN
        m_lock = (m_owner == 0) && core_lock;
`endif
      end else if (!m_busy) begin
        if (m_lock && c_if.req)          begin go = 1; own = 0; end
        else if (c_if.req && d_if.req)   begin go = 1; own = !m_last; m_last = own; end
        else if (c_if.req)               begin go = 1; own = 0; m_last = 0; end
        else if (d_if.req)               begin go = 1; own = 1; m_last = 1; end
        m_lock = 0;
        if (go) begin
          m_busy = 1; m_owner = own; m_start = cyc;
          m_we    = own ? d_if.we    : c_if.we;
          m_addr  = own ? d_if.addr  : c_if.addr;
          m_wdata = own ? d_if.wdata : c_if.wdata;
        end
      end
    end
  end

  // Requester: holds req for n_acc accesses, then drops it. Call #1 after a
  // posedge while the arbiter is idle; returns the cycles from request to ack.
  task automatic apply_stimulus(input bit port, input bit we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input int n_acc,
                                output int first_lat);
    int t0 = cyc;
    int got = 0;
    int waited = 0;
    first_lat = -1;
    if (port) begin d_if.req = 1; d_if.we = we; d_if.addr = addr; d_if.wdata = wdata; end
    else      begin c_if.req = 1; c_if.we = we; c_if.addr = addr; c_if.wdata = wdata; end
    while (got < n_acc && waited < 60) begin
      @(negedge clk);
      waited++;
      if ((port ? d_if.ack : c_if.ack) === 1'b1) begin
        got++;
        if (got == 1) first_lat = cyc - t0;
      end
    end
    if (got < n_acc) check_output(port ? "d_ack_timeout" : "c_ack_timeout", got, n_acc);
    @(posedge clk); #1;
    if (port) d_if.req = 0; else c_if.req = 0;
  endtask

  initial begin
    int lat0, lat1, t0, base, ebase, seen_en, seen_ack;
    logic [DW-1:0] ack_data;
    logic [1:0]    ack_grant;
    int exp_lock [3];
`ifdef MEM_ARB_LOCK_EN
    exp_lock = '{0, 0, 1};
`else
    exp_lock = '{0, 1, 0};
`endif
    reset = 1; core_lock = 0;
    c_if.req = 0;  c_if.we = 0;  c_if.addr = '0;  c_if.wdata = '0;
    d_if.req = 0;  d_if.we = 0;  d_if.addr = '0;  d_if.wdata = '0;
    c3_if.req = 0; c3_if.we = 0; c3_if.addr = '0; c3_if.wdata = '0;
    d3_if.req = 0; d3_if.we = 0; d3_if.addr = '0; d3_if.wdata = '0;
    @(posedge clk); #1;
    check_output("rst_grant", grant, 0);
    check_output("rst_mem_en", mem_en, 0);
    check_output("rst_c_rdata", c_if.rdata, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Core read of 0x10, LAT=1
    t0 = cyc; ebase = en_count;
    apply_stimulus(0, 0, 32'h10, '0, 1, lat0);
    check_output("t1_ack_latency", lat0, 3);
    check_output("t1_en_count", en_count - ebase, 1);
    check_output("t1_en_offset", en_cycle - t0, 1);
    check_output("t1_en_addr", en_addr, 32'h10);
    check_output("t1_c_rdata", c_if.rdata, 32'hDEAD_BEEF);
    check_output("t1_model_rdata", exp_rdata[0], 32'hDEAD_BEEF);

    // DMA write 0x1234 -> 0x20
    t0 = cyc;
    apply_stimulus(1, 1, 32'h20, 32'h1234, 1, lat1);
    check_output("t2_ack_latency", lat1, 3);
    check_output("t2_en_offset", en_cycle - t0, 1);
    check_output("t2_en_we", en_we, 1);
    check_output("t2_en_wdata", en_wdata, 32'h1234);
    check_output("t2_en_addr", en_addr, 32'h20);
    check_output("t2_c_rdata_held", c_if.rdata, 32'hDEAD_BEEF);

    // Both ports held: core, DMA, core, DMA, 4 cycles apart
    base = ack_port_q.size();
    fork
      apply_stimulus(0, 0, 32'h40, '0, 2, lat0);
      apply_stimulus(1, 0, 32'h20, '0, 2, lat1);
    join
    check_output("t3_ack_count", ack_port_q.size() - base, 4);
    if (ack_port_q.size() - base >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check_output("t3_order", ack_port_q[base + i], i % 2);
        if (i > 0) check_output("t3_spacing", ack_cyc_q[base + i] - ack_cyc_q[base + i - 1], 4);
      end
    end
    check_output("t3_d_rdata", d_if.rdata, 32'h1234);

    // core_lock with both requesting
    base = ack_port_q.size();
    core_lock = 1;
    fork
      apply_stimulus(0, 1, 32'h50, 32'hAAAA, 2, lat0);
      apply_stimulus(1, 0, 32'h54, '0, 1, lat1);
    join
    core_lock = 0;
    check_output("t4_ack_count", ack_port_q.size() - base, 3);
    if (ack_port_q.size() - base >= 3)
      for (int i = 0; i < 3; i++) check_output("t4_lock_order", ack_port_q[base + i], exp_lock[i]);

    // LAT=3 core read on u_dut3
    t0 = cyc; seen_en = -1; seen_ack = -1; ack_data = '0; ack_grant = '0;
    c3_if.req = 1; c3_if.addr = 32'h60;
    for (int i = 0; i < 30 && seen_ack < 0; i++) begin
      @(negedge clk);
      if (mem3_en && seen_en < 0) seen_en = cyc - t0;
      if (c3_if.ack) begin seen_ack = cyc - t0; ack_data = c3_if.rdata; ack_grant = grant3; end
    end
    @(posedge clk); #1 c3_if.req = 0;
    check_output("t5_en_offset", seen_en, 1);
    check_output("t5_ack_offset", seen_ack, 5);
    check_output("t5_rdata", ack_data, 32'hCAFE_F00D);
    check_output("t5_grant", ack_grant, 2'b01);

    // Reset during WAIT of a core read
    base = ack_port_q.size();
    c_if.req = 1; c_if.we = 0; c_if.addr = 32'h30;
    repeat (2) @(posedge clk);
    #3 reset = 1;
    #1;
    check_output("t6_grant", grant, 0);
    check_output("t6_mem_en", mem_en, 0);
    check_output("t6_c_ack", c_if.ack, 0);
    check_output("t6_c_rdata", c_if.rdata, 0);
    check_output("t6_d_rdata", d_if.rdata, 0);
    c_if.req = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (3) @(posedge clk);
    #1;
    check_output("t6_no_ack", ack_port_q.size() - base, 0);
    base = ack_port_q.size();
    fork
      apply_stimulus(0, 0, 32'h10, '0, 1, lat0);
      apply_stimulus(1, 0, 32'h44, '0, 1, lat1);
    join
    check_output("t6_post_count", ack_port_q.size() - base, 2);
    if (ack_port_q.size() - base >= 1) check_output("t6_core_first", ack_port_q[base], 0);
    check_output("t6_c_lat", lat0, 3);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
